alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Front-end controller for the ALU. Sits directly upstream of the arithmetic, logic, compare and shift units, and gathers their outputs downstream.
- Accepts one operation at a time over a valid/ready command interface. Decodes alu_fun[3:2] into a one-cycle unit enable, then drives operands and function code.
- Captures the selected unit's registered result and flag exactly one cycle later. Presents the result on a valid/ready result interface.

Parameters:
- WIDTH, 16, operand and result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_fun  in  4  ALU function code.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- alu_fun  out  4  function code to the units.
- a  out  WIDTH  operand A to the units.
- b  out  WIDTH  operand B to the units.
- Arith_EN  out  1  arithmetic unit enable.
- Logic_EN  out  1  logic unit enable.
- CMP_EN  out  1  compare unit enable.
- SHIFT_EN  out  1  shift unit enable.
- arith_out, logic_out, cmp_out, shift_out  in  WIDTH each  registered unit results.
- arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  registered unit flags.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  captured result.
- res_flag  out  1  captured flag.
- res_unit  out  2  unit that produced the result (cmd_fun[3:2]).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state IDLE. alu_fun, a, b, res_data, res_unit = 0. All enables = 0. res_valid = 0, res_flag = 0. Reset mid-operation aborts the operation; the in-flight result is discarded.
- Unit decode (cmd_fun[3:2]): 00 arith, 01 logic, 10 cmp, 11 shift. Exactly one enable is high, for exactly one cycle, per accepted command.
- State IDLE:
  - cmd_ready = 1.
  - On edge with cmd_valid & cmd_ready: latch cmd_fun/cmd_a/cmd_b into alu_fun/a/b; set the decoded enable register to 1; go to ISSUE.
- State ISSUE:
  - The enable is high during this cycle and the units register at the next edge.
  - At that edge: clear all enables; go to CAPTURE.
- State CAPTURE:
  - Unit outputs are valid for this cycle only. The units zero their outputs one cycle after disable, so capture happens in this cycle and no later.
  - At the edge: res_data/res_flag <= selected unit out/flag; res_unit <= alu_fun[3:2]; res_valid <= 1; go to HOLD.
- State HOLD:
  - res_valid = 1. res_data, res_flag and res_unit are held stable while res_ready = 0.
  - On edge with res_ready = 1: res_valid <= 0; go to IDLE.
- Latency: accept edge E0, enable high E0→E1, capture at E2. res_valid is high from E2 onward: 2 cycles from accept to valid.
- Throughput without overlap: 1 operation per 4 cycles with res_ready tied high.
- Busy behaviour: cmd_ready = 0 in ISSUE, CAPTURE and HOLD. cmd_valid during those states is ignored and the command is not lost by the controller; the source holds it.
- alu_fun/a/b hold their latched values after issue until the next accept.
- Registered outputs: all outputs are registered except cmd_ready, which is combinational from state (and res_ready when ALU_OVERLAP_EN is defined).
- The unit result selection is a pure function of the latched alu_fun[3:2].

Optional Feature:
- Macro: ALU_OVERLAP_EN.
- Defined:
  - cmd_ready = IDLE | (HOLD & res_ready).
  - A new command is accepted on the same edge as the result handshake; the next state is ISSUE directly, with res_valid <= 0.
  - Throughput is 1 operation per 3 cycles.
- Undefined: cmd_ready is asserted only in IDLE.

Decomposition:
- Package alu_pkg:
  - Unit codes UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11.
  - State encoding IDLE/ISSUE/CAPTURE/HOLD.
  - UNIT_LATENCY=1.
- Sub-module alu_result_mux (combinational): selects the out/flag pair by unit code. It is instantiated once.

Test Plan:
- Logic AND: cmd_fun=4'b0100, a=16'h00FF, b=16'h0F0F, res_ready=1.
  -> Logic_EN high for exactly 1 cycle after accept.
  -> res_valid 2 cycles after accept; res_data=16'h000F, res_flag=1, res_unit=2'b01.
- Logic NOR: cmd_fun=4'b0111, a=16'hF000, b=16'h000F.
  -> res_data=16'h0FF0, res_flag=1. No other enable ever asserted.
- Backpressure: res_ready=0 for 5 cycles after res_valid.
  -> res_data stable for all 5 cycles; cmd_ready=0 throughout.
  -> A cmd_valid offered meanwhile is not accepted until after the handshake.
- Reset mid-op: assert rst in the CAPTURE cycle.
  -> Next cycle state IDLE, res_valid=0, res_data=0, all enables=0, cmd_ready=1.
- Back-to-back: 3 commands offered continuously, res_ready=1.
  -> Accepts every 4 cycles without ALU_OVERLAP_EN, every 3 cycles with it.
  -> Results appear in order with the correct res_unit each time.
- Unit decode sweep: cmd_fun[3:2]=00,01,10,11 with stub units returning distinct constants.
  -> Each result matches its unit's constant; the corresponding single enable is pulsed for each.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller.
//   - Unit codes as carried in alu_fun[3:2].
//   - Controller state encoding.
//   - UNIT_LATENCY: cycles from unit enable to the unit's registered result.
//   - unit_onehot(): maps a unit code to its one-hot enable vector.
package alu_pkg;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   localparam int unsigned UNIT_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } alu_state_e;

   // Bit n of the result is the enable for unit code n.
   function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
      logic [3:0] oh;
      oh = 4'b0000;
      oh[unit] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/alu_result_mux.sv
// alu_result_mux: combinational selection of one unit's result/flag pair.
// Ports:
//   unit                          unit code (alu_fun[3:2])
//   arith/logic/cmp/shift _out    registered unit results
//   arith/logic/cmp/shift _flag   registered unit flags
//   sel_data, sel_flag            selected result and flag
module alu_result_mux
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [1:0]       unit,
   input  logic [WIDTH-1:0] arith_out,
   input  logic [WIDTH-1:0] logic_out,
   input  logic [WIDTH-1:0] cmp_out,
   input  logic [WIDTH-1:0] shift_out,
   input  logic             arith_flag,
   input  logic             logic_flag,
   input  logic             cmp_flag,
   input  logic             shift_flag,
   output logic [WIDTH-1:0] sel_data,
   output logic             sel_flag
);

   always_comb begin
      sel_data = '0;
      sel_flag = 1'b0;
      unique case (unit)
         UNIT_ARITH: begin
            sel_data = arith_out;
            sel_flag = arith_flag;
         end
         UNIT_LOGIC: begin
            sel_data = logic_out;
            sel_flag = logic_flag;
         end
         UNIT_CMP: begin
            sel_data = cmp_out;
            sel_flag = cmp_flag;
         end
         UNIT_SHIFT: begin
            sel_data = shift_out;
            sel_flag = shift_flag;
         end
         default: begin
            sel_data = '0;
            sel_flag = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: front-end controller for the ALU units.
// Accepts one command over cmd_valid/cmd_ready, pulses the decoded unit
// enable for one cycle, captures that unit's registered result one cycle
// later and offers it over res_valid/res_ready.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/fun/a/b   command interface
//   alu_fun, a, b             function code and operands to the units
//   Arith_EN .. SHIFT_EN      one-cycle unit enables
//   *_out, *_flag             registered unit results and flags
//   res_valid/ready/data/flag/unit  result interface
// Build option: define ALU_OVERLAP_EN to accept a new command on the same
// edge as the result handshake (1 op per 3 cycles instead of 4).
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_fun,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [3:0]       alu_fun,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             Arith_EN,
   output logic             Logic_EN,
   output logic             CMP_EN,
   output logic             SHIFT_EN,
   input  logic [WIDTH-1:0] arith_out,
   input  logic [WIDTH-1:0] logic_out,
   input  logic [WIDTH-1:0] cmp_out,
   input  logic [WIDTH-1:0] shift_out,
   input  logic             arith_flag,
   input  logic             logic_flag,
   input  logic             cmp_flag,
   input  logic             shift_flag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_flag,
   output logic [1:0]       res_unit
);

   alu_state_e       state_q, state_d;
   logic [3:0]       fun_q, fun_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       en_q, en_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_flag_q, res_flag_d;
   logic [1:0]       res_unit_q, res_unit_d;

   logic [WIDTH-1:0] sel_data;
   logic             sel_flag;
   logic             accept;

   // Selection depends only on the latched function code, which is stable
   // from issue until the next accept.
   alu_result_mux #(
      .WIDTH (WIDTH)
   ) u_result_mux (
      .unit       (fun_q[3:2]),
      .arith_out  (arith_out),
      .logic_out  (logic_out),
      .cmp_out    (cmp_out),
      .shift_out  (shift_out),
      .arith_flag (arith_flag),
      .logic_flag (logic_flag),
      .cmp_flag   (cmp_flag),
      .shift_flag (shift_flag),
      .sel_data   (sel_data),
      .sel_flag   (sel_flag)
   );

   always_comb begin
      cmd_ready = (state_q == IDLE);
`ifdef ALU_OVERLAP_EN
      if ((state_q == HOLD) && res_ready) begin
         cmd_ready = 1'b1;
      end
`endif
   end

   assign accept = cmd_valid & cmd_ready;

   always_comb begin
      state_d     = state_q;
      fun_d       = fun_q;
      a_d         = a_q;
      b_d         = b_q;
      en_d        = 4'b0000;   // enables are single-cycle pulses
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_flag_d  = res_flag_q;
      res_unit_d  = res_unit_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               fun_d   = cmd_fun;
               a_d     = cmd_a;
               b_d     = cmd_b;
               en_d    = unit_onehot(cmd_fun[3:2]);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            // Units clear their outputs a cycle after disable: this is the
            // only cycle the selected result is present.
            res_data_d  = sel_data;
            res_flag_d  = sel_flag;
            res_unit_d  = fun_q[3:2];
            res_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
`ifdef ALU_OVERLAP_EN
               if (accept) begin
                  fun_d   = cmd_fun;
                  a_d     = cmd_a;
                  b_d     = cmd_b;
                  en_d    = unit_onehot(cmd_fun[3:2]);
                  state_d = ISSUE;
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fun_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         en_q        <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_flag_q  <= 1'b0;
         res_unit_q  <= '0;
      end else begin
         state_q     <= state_d;
         fun_q       <= fun_d;
         a_q         <= a_d;
         b_q         <= b_d;
         en_q        <= en_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_flag_q  <= res_flag_d;
         res_unit_q  <= res_unit_d;
      end
   end

   assign alu_fun   = fun_q;
   assign a         = a_q;
   assign b         = b_q;
   assign Arith_EN  = en_q[UNIT_ARITH];
   assign Logic_EN  = en_q[UNIT_LOGIC];
   assign CMP_EN    = en_q[UNIT_CMP];
   assign SHIFT_EN  = en_q[UNIT_SHIFT];
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_flag  = res_flag_q;
   assign res_unit  = res_unit_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: stub units, a cycle-level reference model of
// the handshake timing and a result scoreboard.
module tb_alu_issue_ctrl;

   localparam int WIDTH = 16;
`ifdef ALU_OVERLAP_EN
   localparam bit OVL = 1'b1;
   localparam int GAP = 3;
`else
   localparam bit OVL = 1'b0;
   localparam int GAP = 4;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_fun = 4'h0;
   logic [WIDTH-1:0] cmd_a = '0;
   logic [WIDTH-1:0] cmd_b = '0;
   logic [3:0]       alu_fun;
   logic [WIDTH-1:0] a, b;
   logic             Arith_EN, Logic_EN, CMP_EN, SHIFT_EN;
   logic [WIDTH-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
   logic             arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_flag;
   logic [1:0]       res_unit;

   logic rr_dir = 1'b0;
   logic rr_rand = 1'b0;
   bit   rand_mode = 1'b0;
   assign res_ready = rand_mode ? rr_rand : rr_dir;

   alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_fun    (cmd_fun),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_fun    (alu_fun),
      .a          (a),
      .b          (b),
      .Arith_EN   (Arith_EN),
      .Logic_EN   (Logic_EN),
      .CMP_EN     (CMP_EN),
      .SHIFT_EN   (SHIFT_EN),
      .arith_out  (arith_out),
      .logic_out  (logic_out),
      .cmp_out    (cmp_out),
      .shift_out  (shift_out),
      .arith_flag (arith_flag),
      .logic_flag (logic_flag),
      .cmp_flag   (cmp_flag),
      .shift_flag (shift_flag),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_flag   (res_flag),
      .res_unit   (res_unit)
   );

   always #5 clk = ~clk;

   // Behaviour of the four units: {flag, result}.
   function automatic logic [16:0] unit_fn(input logic [3:0] f, input logic [15:0] x,
                                           input logic [15:0] y);
      logic [16:0] w;
      logic [15:0] r;
      logic        fl;
      w = 17'd0;
      r = 16'd0;
      fl = 1'b0;
      case (f[3:2])
         2'b00: begin
            case (f[1:0])
               2'b00:   w = {1'b0, x} + {1'b0, y};
               2'b01:   w = {1'b0, x} - {1'b0, y};
               2'b10:   w = {1'b0, x} + 17'd1;
               default: w = {1'b0, x} - 17'd1;
            endcase
            r = w[15:0];
            fl = w[16];
         end
         2'b01: begin
            case (f[1:0])
               2'b00:   r = x & y;
               2'b01:   r = x | y;
               2'b10:   r = x ^ y;
               default: r = ~(x | y);
            endcase
            fl = |r;
         end
         2'b10: begin
            case (f[1:0])
               2'b00:   fl = (x == y);
               2'b01:   fl = (x > y);
               2'b10:   fl = (x < y);
               default: fl = (x != y);
            endcase
            r = fl ? 16'hCCC1 : 16'hCCC0;
         end
         default: begin
            case (f[1:0])
               2'b00:   r = x << y[3:0];
               2'b01:   r = x >> y[3:0];
               2'b10:   r = 16'($signed(x) >>> y[3:0]);
               default: r = {x[14:0], x[15]};
            endcase
            fl = |r;
         end
      endcase
      return {fl, r};
   endfunction

   // Stub units: register a result when enabled, return zero otherwise.
   logic [16:0] stub_res;
   assign stub_res = unit_fn(alu_fun, a, b);
   always @(posedge clk) begin
      arith_out  <= Arith_EN ? stub_res[15:0] : 16'h0;
      arith_flag <= Arith_EN & stub_res[16];
      logic_out  <= Logic_EN ? stub_res[15:0] : 16'h0;
      logic_flag <= Logic_EN & stub_res[16];
      cmp_out    <= CMP_EN ? stub_res[15:0] : 16'h0;
      cmp_flag   <= CMP_EN & stub_res[16];
      shift_out  <= SHIFT_EN ? stub_res[15:0] : 16'h0;
      shift_flag <= SHIFT_EN & stub_res[16];
   end

   typedef struct packed {
      logic [15:0] data;
      logic        flag;
      logic [1:0]  unit;
   } res_t;

   res_t        exp_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          fails = 0;
   bit          armed = 1'b0;
   bit          busy = 1'b0;
   int          acc_cyc = 0;
   bit          acc_flag = 1'b0;
   logic [3:0]  m_fun = 4'h0;
   logic [15:0] m_a = 16'h0;
   logic [15:0] m_b = 16'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) rr_rand <= 1'($urandom_range(0, 1));

   // Reference model: an operation accepted at the edge that starts cycle k
   // has its enable in cycle k and its result valid from cycle k+2 until the
   // handshake. Only one operation is in flight at a time.
   always @(negedge clk) begin
      bit         ev;
      bit         erdy;
      logic [3:0] een;
      logic [16:0] rr;
      res_t       r;
      ev   = busy && (cyc >= acc_cyc + 2);
      een  = (busy && cyc == acc_cyc) ? (4'b0001 << m_fun[3:2]) : 4'b0000;
      erdy = !busy || (OVL && ev && res_ready);
      if (armed) begin
         check("cmd_ready", 32'(cmd_ready), 32'(erdy));
         check("enables", 32'({SHIFT_EN, CMP_EN, Logic_EN, Arith_EN}), 32'(een));
         check("res_valid", 32'(res_valid), 32'(ev));
         check("alu_fun", 32'(alu_fun), 32'(m_fun));
         check("operand_a", 32'(a), 32'(m_a));
         check("operand_b", 32'(b), 32'(m_b));
      end
      if (rst) begin
         busy  = 1'b0;
         m_fun = 4'h0;
         m_a   = 16'h0;
         m_b   = 16'h0;
         exp_q.delete();
         armed = 1'b1;
      end else if (armed) begin
         if (ev && res_ready) busy = 1'b0;
         if (cmd_valid && erdy) begin
            busy    = 1'b1;
            acc_cyc = cyc + 1;
            m_fun   = cmd_fun;
            m_a     = cmd_a;
            m_b     = cmd_b;
            rr      = unit_fn(cmd_fun, cmd_a, cmd_b);
            r.data  = rr[15:0];
            r.flag  = rr[16];
            r.unit  = cmd_fun[3:2];
            exp_q.push_back(r);
            acc_flag = 1'b1;
         end
      end
   end

   // Monitor: compare each presented result against the scoreboard head.
   always @(negedge clk) begin
      if (armed && !rst && res_valid) begin
         check("result_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check("res_data", 32'(res_data), 32'(exp_q[0].data));
            check("res_flag", 32'(res_flag), 32'(exp_q[0].flag));
            check("res_unit", 32'(res_unit), 32'(exp_q[0].unit));
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [3:0] f, input logic [15:0] av, input logic [15:0] bv);
      int n;
      cmd_fun   = f;
      cmd_a     = av;
      cmd_b     = bv;
      acc_flag  = 1'b0;
      cmd_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!acc_flag && n < 60);
      check("accept_in_time", 32'(acc_flag), 32'd1);
      #1;
      cmd_valid = 1'b0;
      acc_flag  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_res_data", 32'(res_data), 32'd0);
      check("reset_res_valid", 32'(res_valid), 32'd0);
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      rr_dir = 1'b1;

      // Logic AND
      send(4'b0100, 16'h00FF, 16'h0F0F);
      check("and_enable_issue", 32'(Logic_EN), 32'd1);
      @(posedge clk); #1;
      check("and_enable_cleared", 32'(Logic_EN), 32'd0);
      @(posedge clk); #1;
      check("and_valid", 32'(res_valid), 32'd1);
      check("and_data", 32'(res_data), 32'h000F);
      check("and_flag", 32'(res_flag), 32'd1);
      check("and_unit", 32'(res_unit), 32'd1);
      repeat (2) @(posedge clk); #1;

      // Logic NOR
      send(4'b0111, 16'hF000, 16'h000F);
      repeat (2) @(posedge clk); #1;
      check("nor_data", 32'(res_data), 32'h0FF0);
      check("nor_flag", 32'(res_flag), 32'd1);
      repeat (2) @(posedge clk); #1;

      // Backpressure with a second command waiting
      rr_dir = 1'b0;
      send(4'b0000, 16'h1234, 16'h4321);
      fork
         send(4'b1101, 16'h0005, 16'h0003);
         begin
            repeat (7) @(posedge clk);
            #1 rr_dir = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;

      // Reset during CAPTURE
      send(4'b1100, 16'h00F0, 16'h0002);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midop_res_valid", 32'(res_valid), 32'd0);
      check("midop_res_data", 32'(res_data), 32'd0);
      check("midop_enables", 32'({SHIFT_EN, CMP_EN, Logic_EN, Arith_EN}), 32'd0);
      check("midop_cmd_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Back-to-back
      send(4'b0001, 16'h0100, 16'h0001);
      t0 = cyc;
      send(4'b1001, 16'h0009, 16'h0003);
      t1 = cyc;
      send(4'b1110, 16'h8000, 16'h0004);
      t2 = cyc;
      check("b2b_gap_1", 32'(t1 - t0), 32'(GAP));
      check("b2b_gap_2", 32'(t2 - t1), 32'(GAP));
      repeat (4) @(posedge clk); #1;

      // Unit decode sweep
      for (int u = 0; u < 4; u++) begin
         send({2'(u), 2'($urandom_range(0, 3))}, 16'($urandom), 16'($urandom));
      end

      // Randomized traffic with random result backpressure
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send(4'($urandom), 16'($urandom), 16'($urandom));
      end
      rand_mode = 1'b0;
      rr_dir = 1'b1;
      repeat (10) @(posedge clk); #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("final_idle_ready", 32'(cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
